// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the DE2 asynchronous SRAM initiator.
// The state enum is also exposed through the debug struct on the top level.
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    TURN
  } sram_state_t;

  typedef struct packed {
    sram_state_t state;
    logic        io_oe;
  } sram_dbg_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_controller.sv
// Single-word valid/ready initiator for the DE2 asynchronous 16-bit SRAM.
// Every SRAM pin and the I_O driver enable are registered from the next state.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int READ_WAIT  = 1,
  parameter int WRITE_WAIT = 1,
  parameter int TURNAROUND = 1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [SRAM_ADDR_W-1:0] req_addr,
  input  logic [SRAM_DATA_W-1:0] req_wdata,
  input  logic [1:0]             req_be,
  output logic                   rsp_valid,
  output logic [SRAM_DATA_W-1:0] rsp_rdata,
  output logic [SRAM_ADDR_W-1:0] A,
  inout  wire  [SRAM_DATA_W-1:0] I_O,
  output logic                   CE,
  output logic                   OE,
  output logic                   WE,
  output logic                   UB,
  output logic                   LB,
  output sram_dbg_t              dbg
);

  // Handshake: a request transfers on the Clk edge where req_valid && req_ready;
  // req_ready is high only in IDLE (and never while Reset is high).

  localparam int CNT_W = $clog2(max3(READ_WAIT, WRITE_WAIT, TURNAROUND) + 2);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(READ_WAIT);
  localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WRITE_WAIT);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURNAROUND - 1);
  localparam int HALF = SRAM_DATA_W / 2;

  sram_state_t state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [SRAM_DATA_W-1:0] wdata_q;
  logic [1:0] be_q, be_sel;
  logic accept, io_oe;
  logic ce_d, oe_d, we_d, ub_d, lb_d, io_oe_d, rsp_valid_d;

  assign req_ready = (state == IDLE) && !Reset;
  assign accept    = req_valid && req_ready;
  // Lane enables must follow the incoming request on the accept edge itself.
  assign be_sel    = accept ? req_be : be_q;

  assign I_O = io_oe ? wdata_q : {SRAM_DATA_W{1'bz}};

  assign dbg.state = state;
  assign dbg.io_oe = io_oe;

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    unique case (state)
      IDLE: begin
        cnt_next = '0;
        if (accept) begin
          if (req_be == 2'b00) state_next = TURN;
          else if (!req_we)    state_next = RD;
          else                 state_next = WR_SETUP;
        end
      end
      RD:       if (cnt == RD_LAST) state_next = TURN;
      WR_SETUP: state_next = WR_PULSE;
      WR_PULSE: if (cnt == WR_LAST) state_next = WR_HOLD;
      WR_HOLD:  state_next = TURN;
      TURN:     if (cnt == TURN_LAST) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    if (state_next != state) cnt_next = '0;
  end

  always_comb begin
    ce_d    = 1'b1;
    oe_d    = 1'b1;
    we_d    = 1'b1;
    ub_d    = 1'b1;
    lb_d    = 1'b1;
    io_oe_d = 1'b0;
    case (state_next)
      RD: begin
        ce_d = 1'b0;
        oe_d = 1'b0;
        ub_d = ~be_sel[1];
        lb_d = ~be_sel[0];
      end
      WR_SETUP, WR_HOLD: begin
        ce_d    = 1'b0;
        ub_d    = ~be_sel[1];
        lb_d    = ~be_sel[0];
        io_oe_d = 1'b1;
      end
      WR_PULSE: begin
        ce_d    = 1'b0;
        we_d    = 1'b0;
        ub_d    = ~be_sel[1];
        lb_d    = ~be_sel[0];
        io_oe_d = 1'b1;
      end
      default: ;
    endcase
    rsp_valid_d = (state_next == TURN) && (state != TURN);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      A         <= '0;
      CE        <= 1'b1;
      OE        <= 1'b1;
      WE        <= 1'b1;
      UB        <= 1'b1;
      LB        <= 1'b1;
      io_oe     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      CE        <= ce_d;
      OE        <= oe_d;
      WE        <= we_d;
      UB        <= ub_d;
      LB        <= lb_d;
      io_oe     <= io_oe_d;
      rsp_valid <= rsp_valid_d;
      if (accept) begin
        wdata_q <= req_wdata;
        be_q    <= req_be;
        // A zero-lane request leaves the address pins untouched.
        if (req_be != 2'b00) A <= req_addr;
        if (req_we || req_be == 2'b00) rsp_rdata <= '0;
      end
      if (state == RD && cnt == RD_LAST)
        rsp_rdata <= I_O & {{HALF{be_q[1]}}, {HALF{be_q[0]}}};
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed plus randomized bench for sram_controller against a pin-level SRAM
// model (preloaded word[n]=n) and a word-level reference memory.
module tb_sram_controller;
  import sram_ctrl_pkg::*;

  localparam int RW = 1;
  localparam int WW = 1;
  localparam int TA = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [19:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  req_be = '0;
  logic        req_ready, rsp_valid;
  logic [15:0] rsp_rdata;
  logic [19:0] a_pin;
  logic        ce, oe, we_n, ub, lb;
  sram_dbg_t   dbg;
  wire  [15:0] sram_io;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  sram_controller #(.READ_WAIT(RW), .WRITE_WAIT(WW), .TURNAROUND(TA)) dut (
    .Clk(clk), .Reset(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .A(a_pin), .I_O(sram_io),
    .CE(ce), .OE(oe), .WE(we_n), .UB(ub), .LB(lb), .dbg(dbg)
  );

  // Pin-level SRAM model: drives on CE&OE low, latches lanes at the WE rising edge.
  logic [15:0] sram_mem [logic [19:0]];
  logic [15:0] sram_q;
  logic [15:0] sram_w;

  function automatic logic [15:0] sram_word(input logic [19:0] ad);
    if (sram_mem.exists(ad)) return sram_mem[ad];
    return ad[15:0];
  endfunction

  always @(a_pin or ce or oe or we_n) sram_q = sram_word(a_pin);
  assign sram_io = (!ce && !oe && we_n) ? sram_q : 16'hzzzz;

  always @(posedge we_n) begin
    if (ce === 1'b0) begin
      sram_w = sram_word(a_pin);
      if (!ub) sram_w[15:8] = sram_io[15:8];
      if (!lb) sram_w[7:0]  = sram_io[7:0];
      sram_mem[a_pin] = sram_w;
    end
  end

  // Reference memory at transaction level.
  logic [15:0] exp_mem [logic [19:0]];

  function automatic logic [15:0] exp_word(input logic [19:0] ad);
    if (exp_mem.exists(ad)) return exp_mem[ad];
    return ad[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pin invariants sampled every cycle outside reset.
  logic        prev_ce = 1'b1;
  logic [19:0] prev_a;
  logic        prev_ub, prev_lb;

  always @(negedge clk) begin
    if (rst || !mon_en) begin
      prev_ce = 1'b1;
    end else begin
      check("inv_oe_with_drive", 32'(!oe && dbg.io_oe), 32'(0));
      check("inv_we_low_ctrl", 32'(!we_n && (ce || !oe)), 32'(0));
      check("inv_drive_outside_wr", 32'(dbg.io_oe && (ce || !oe)), 32'(0));
      if (!prev_ce && !ce)
        check("inv_pins_stable", 32'({a_pin, ub, lb}), 32'({prev_a, prev_ub, prev_lb}));
      prev_ce = ce;
      prev_a  = a_pin;
      prev_ub = ub;
      prev_lb = lb;
    end
  end

  task automatic txn(input logic w, input logic [19:0] ad, input logic [15:0] wd,
                     input logic [1:0] be, input string tag);
    int n, cyc, ce_lo, oe_lo, we_lo, lat, exp_ce, exp_oe, exp_we;
    bit got, pins_ok;
    logic [15:0] exp_rd, mask;
    n = 0; cyc = 0; ce_lo = 0; oe_lo = 0; we_lo = 0; got = 0; pins_ok = 1; exp_rd = '0;
    mask = {{8{be[1]}}, {8{be[0]}}};
    @(negedge clk);
    req_valid = 1'b1; req_we = w; req_addr = ad; req_wdata = wd; req_be = be;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'(1));
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (be == 2'b00) begin
      lat = 1; exp_ce = 0; exp_oe = 0; exp_we = 0;
    end else if (!w) begin
      lat = RW + 2; exp_ce = RW + 1; exp_oe = RW + 1; exp_we = 0;
      exp_rd = exp_word(ad) & mask;
    end else begin
      lat = WW + 4; exp_ce = WW + 3; exp_oe = 0; exp_we = WW + 1;
      exp_mem[ad] = (exp_word(ad) & ~mask) | (wd & mask);
    end
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (!ce) begin
        ce_lo++;
        if (a_pin !== ad || ub !== ~be[1] || lb !== ~be[0]) pins_ok = 0;
      end
      if (!oe) oe_lo++;
      if (!we_n) we_lo++;
      got = rsp_valid;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(lat));
    if (!w || be == 2'b00) check({tag, "_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
    check({tag, "_ce_cycles"}, 32'(ce_lo), 32'(exp_ce));
    check({tag, "_oe_cycles"}, 32'(oe_lo), 32'(exp_oe));
    check({tag, "_we_cycles"}, 32'(we_lo), 32'(exp_we));
    check({tag, "_addr_lanes"}, 32'(pins_ok), 32'(1));
    @(negedge clk);
    check({tag, "_rsp_one_cycle"}, 32'(rsp_valid), 32'(0));
    repeat (TA - 1) @(negedge clk);
    check({tag, "_ready_again"}, 32'(req_ready), 32'(1));
  endtask

  initial begin
    int ph, gap, rsp_n;
    bit acc2;
    logic [15:0] rd1;
    logic [19:0] ad;

    // Reset state
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ctrl_pins", 32'({ce, oe, we_n, ub, lb}), 32'(5'b11111));
    check("rst_addr", 32'(a_pin), 32'(0));
    check("rst_io_drive", 32'(dbg.io_oe), 32'(0));
    check("rst_rsp", 32'({rsp_valid, rsp_rdata}), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'(1));
    mon_en = 1'b1;

    // Basic read, write-then-read, byte-lane merges
    txn(1'b0, 20'h00005, 16'h0000, 2'b11, "t1_rd5");
    txn(1'b1, 20'h00010, 16'hBEEF, 2'b11, "t2_wr10");
    txn(1'b0, 20'h00010, 16'h0000, 2'b11, "t2_rd10");
    txn(1'b1, 20'h00020, 16'h12AB, 2'b01, "t3_wr_lo");
    txn(1'b1, 20'h00020, 16'hCD00, 2'b10, "t3_wr_hi");
    txn(1'b0, 20'h00020, 16'h0000, 2'b11, "t3_rd_both");
    txn(1'b0, 20'h00020, 16'h0000, 2'b01, "t3_rd_lo");

    // Back-to-back with req_valid held: read 3 then write 3
    @(negedge clk);
    check("t4_ready0", 32'(req_ready), 32'(1));
    req_valid = 1'b1; req_we = 1'b0; req_addr = 20'h00003; req_be = 2'b11;
    @(posedge clk);
    #1 req_we = 1'b1; req_wdata = 16'h5555;
    ph = 0; gap = 0; rsp_n = 0; acc2 = 0; rd1 = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      case (ph)
        0: if (!ce) ph = 1;
        1: if (ce) begin ph = 2; gap = 1; end
        2: if (!ce) ph = 3; else gap++;
        default: ;
      endcase
      if (rsp_valid) begin
        if (rsp_n == 0) rd1 = rsp_rdata;
        rsp_n++;
      end
      if (req_ready && !acc2) begin
        acc2 = 1;
        @(posedge clk);
        #1 req_valid = 1'b0;
      end
    end
    exp_mem[20'h00003] = 16'h5555;
    check("t4_first_rdata", 32'(rd1), 32'(16'h0003));
    check("t4_second_accepted", 32'(acc2), 32'(1));
    check("t4_two_responses", 32'(rsp_n), 32'(2));
    check("t4_gap_seen", 32'(ph), 32'(3));
    check("t4_gap_min", 32'(gap >= TA + 1), 32'(1));
    txn(1'b0, 20'h00003, 16'h0000, 2'b11, "t4_rd3");

    // Zero byte enables: no access, immediate response with zero data
    txn(1'b1, 20'h00030, 16'hFFFF, 2'b00, "t5_be00");

    // Reset during the second WE-low cycle of a write
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 20'h00040; req_wdata = 16'hAAAA; req_be = 2'b11;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_in_pulse", 32'(we_n), 32'(0));
    rst = 1'b1;
    #1;
    check("t6_pins_high", 32'({ce, oe, we_n}), 32'(3'b111));
    check("t6_io_release", 32'(dbg.io_oe), 32'(0));
    check("t6_no_rsp", 32'(rsp_valid), 32'(0));
    repeat (2) begin
      @(negedge clk);
      check("t6_no_rsp_hold", 32'(rsp_valid), 32'(0));
    end
    rst = 1'b0;
    @(negedge clk);
    check("t6_ready", 32'(req_ready), 32'(1));
    check("t6_no_rsp_after", 32'(rsp_valid), 32'(0));
    txn(1'b0, 20'h00007, 16'h0000, 2'b11, "t6_rd7");

    // Randomized traffic near both address extremes
    for (int k = 0; k < 40; k++) begin
      ad = ($urandom_range(0, 1) ? 20'hFFFE0 : 20'h00100) + 20'($urandom_range(0, 31));
      txn(1'($urandom_range(0, 1)), ad, 16'($urandom), 2'($urandom_range(0, 3)), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
